// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared FSM encoding and default widths for the instruction cache
package inst_cache_pkg;

   typedef enum logic [1:0] {
      ICACHE_IDLE   = 2'd0,
      ICACHE_REFILL = 2'd1,
      ICACHE_FILLED = 2'd2
   } icache_state_t;

   localparam int INST_ADDR_W    = 32;
   localparam int INST_W         = 32;
   localparam int ICACHE_INDEX_W = 4;
   localparam int ICACHE_TAG_W   = 24;

   function automatic int icache_tag_w(input int aw, input int nl, input int lw);
      return aw - 2 - $clog2(nl) - $clog2(lw);
   endfunction

endpackage

// File: rtl/inst_cache_store.sv
// icache_store: data/tag/valid arrays, sync write, async read, flush-all of valid bits
module icache_store #(
   parameter  int NUM_LINES  = 16,
   parameter  int LINE_WORDS = 4,
   parameter  int TAG_W      = 24,
   localparam int IDX_W      = $clog2(NUM_LINES),
   localparam int OFF_W      = $clog2(LINE_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [OFF_W-1:0] woff,
   input  logic [31:0]      wdata,
   input  logic             tag_we,
   input  logic [TAG_W-1:0] wtag,
   input  logic             set_valid,
   input  logic [IDX_W-1:0] ridx,
   input  logic [OFF_W-1:0] roff,
   output logic [31:0]      rdata,
   output logic [TAG_W-1:0] rtag,
   output logic             rvalid
);

   logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [NUM_LINES-1:0] valid;

   // data and tag arrays take refill writes only; no reset needed
   always_ff @(posedge clk) begin
      if (we) data_mem[{widx, woff}] <= wdata;
      if (tag_we) tag_mem[widx] <= wtag;
   end

   // valid bits: cleared by reset or flush, set when a clean refill completes
   always_ff @(posedge clk) begin
      if (rst || flush) valid <= '0;
      else if (tag_we && set_valid) valid[widx] <= 1'b1;
   end

   assign rdata  = data_mem[{ridx, roff}];
   assign rtag   = tag_mem[ridx];
   assign rvalid = valid[ridx];

endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache; optional INST_CACHE_STATS_EN adds hit/miss counters
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int ADDR_W     = INST_ADDR_W,
   parameter int NUM_LINES  = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_ce,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [31:0]       cpu_inst,
   output logic              stall_req,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_data
`ifdef INST_CACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = icache_tag_w(ADDR_W, NUM_LINES, LINE_WORDS);
   localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

   icache_state_t    state;
   logic [OFF_W-1:0] cnt;
   logic             flush_pend;
   logic [31:0]      rdata;
   logic [TAG_W-1:0] rtag;
   logic             rvalid;
   logic             hit;
   logic             we;
   logic             addr_unused;

   assign addr_unused = ^{cpu_addr[1:0], mem_addr[1:0]};
   assign hit       = cpu_ce && rvalid && rtag == cpu_addr[ADDR_W-1 -: TAG_W] && state == ICACHE_IDLE;
   assign cpu_inst  = hit ? rdata : 32'h0;
   assign stall_req = cpu_ce && !hit;
   assign we        = state == ICACHE_REFILL && mem_ack;

   icache_store #(
      .NUM_LINES (NUM_LINES),
      .LINE_WORDS(LINE_WORDS),
      .TAG_W     (TAG_W)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .we       (we),
      .widx     (mem_addr[OFF_W+2 +: IDX_W]),
      .woff     (cnt),
      .wdata    (mem_data),
      .tag_we   (we && cnt == LAST),
      .wtag     (mem_addr[ADDR_W-1 -: TAG_W]),
      .set_valid(!(flush || flush_pend)),
      .ridx     (cpu_addr[OFF_W+2 +: IDX_W]),
      .roff     (cpu_addr[2 +: OFF_W]),
      .rdata    (rdata),
      .rtag     (rtag),
      .rvalid   (rvalid)
   );

   // refill FSM: latch line base on a miss, walk the words, one settle cycle in FILLED
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ICACHE_IDLE;
         cnt        <= '0;
         flush_pend <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
      end else begin
         case (state)
            ICACHE_IDLE: if (cpu_ce && !hit) begin
               state    <= ICACHE_REFILL;
               cnt      <= '0;
               mem_req  <= 1'b1;
               mem_addr <= {cpu_addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
            end
            ICACHE_REFILL: begin
               if (flush) flush_pend <= 1'b1;
               if (mem_ack && cnt == LAST) begin
                  state   <= ICACHE_FILLED;
                  mem_req <= 1'b0;
               end else if (mem_ack) begin
                  cnt      <= cnt + 1'b1;
                  mem_addr <= mem_addr + ADDR_W'(4);
               end
            end
            ICACHE_FILLED: begin
               state      <= ICACHE_IDLE;
               flush_pend <= 1'b0;
            end
            default: state <= ICACHE_IDLE;
         endcase
      end
   end

`ifdef INST_CACHE_STATS_EN
   // hit/miss counters, cleared by reset or flush, wrap naturally
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         hit_cnt  <= hit_cnt + {31'd0, hit};
         miss_cnt <= miss_cnt + {31'd0, state == ICACHE_IDLE && cpu_ce && !hit};
      end
   end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed self-checking bench for inst_cache
module tb_inst_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_ce;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_inst;
   logic        stall_req;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_data;
`ifdef INST_CACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign mem_data = 32'h1000 + {2'b00, mem_addr[31:2]};

   inst_cache dut (
      .clk      (clk),
      .rst      (rst),
      .cpu_ce   (cpu_ce),
      .cpu_addr (cpu_addr),
      .cpu_inst (cpu_inst),
      .stall_req(stall_req),
      .flush    (flush),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_data (mem_data)
`ifdef INST_CACHE_STATS_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic refill_fast(input logic [31:0] a);
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("refill_stall", {31'd0, stall_req}, 32'd1);
         if (k >= 1 && k <= 4) begin
            chk("refill_req", {31'd0, mem_req}, 32'd1);
            chk("refill_addr", mem_addr, a + 32'(4 * (k - 1)));
         end
         step();
      end
   endtask

   initial begin
      rst = 1'b1; cpu_ce = 1'b0; cpu_addr = '0; flush = 1'b0; mem_ack = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_stall", {31'd0, stall_req}, 32'd0);
      chk("rst_inst", cpu_inst, 32'h0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
`ifdef INST_CACHE_STATS_EN
      chk("rst_hits", hit_cnt, 32'd0);
      chk("rst_miss", miss_cnt, 32'd0);
`endif
      step();
      // cold miss at 0x0, memory acks every cycle
      cpu_ce = 1'b1; cpu_addr = 32'h0; mem_ack = 1'b1;
      refill_fast(32'h0);
      #1;
      chk("cold_hit_stall", {31'd0, stall_req}, 32'd0);
      chk("cold_hit_inst", cpu_inst, 32'h1000);
      step();
      // sequential hits in the same line
      for (int w = 1; w < 4; w++) begin
         cpu_addr = 32'(4 * w);
         #1;
         chk("seq_inst", cpu_inst, 32'h1000 + 32'(w));
         chk("seq_stall", {31'd0, stall_req}, 32'd0);
         chk("seq_req", {31'd0, mem_req}, 32'd0);
         step();
      end
      // cpu_ce low: no output, no stall, no refill
      cpu_ce = 1'b0; cpu_addr = 32'h0;
      #1;
      chk("ce_low_inst", cpu_inst, 32'h0);
      chk("ce_low_stall", {31'd0, stall_req}, 32'd0);
      step();
      chk("ce_low_req", {31'd0, mem_req}, 32'd0);
      // conflict eviction: 0x100 shares index 0 with 0x0
      cpu_ce = 1'b1; cpu_addr = 32'h100;
      refill_fast(32'h100);
      #1;
      chk("conflict_inst", cpu_inst, 32'h1040);
      step();
      cpu_addr = 32'h0;
      refill_fast(32'h0);
      #1;
      chk("refetch_inst", cpu_inst, 32'h1000);
      step();
      // slow memory: ack every third cycle
      cpu_addr = 32'h200; mem_ack = 1'b0;
      #1;
      chk("slow_miss", {31'd0, stall_req}, 32'd1);
      step();
      for (int w = 0; w < 4; w++) begin
         for (int p = 0; p < 3; p++) begin
            mem_ack = (p == 2);
            #1;
            chk("slow_req", {31'd0, mem_req}, 32'd1);
            chk("slow_addr", mem_addr, 32'h200 + 32'(4 * w));
            chk("slow_stall", {31'd0, stall_req}, 32'd1);
            step();
         end
      end
      mem_ack = 1'b0;
      #1;
      chk("slow_filled_stall", {31'd0, stall_req}, 32'd1);
      chk("slow_filled_req", {31'd0, mem_req}, 32'd0);
      step();
      chk("slow_inst", cpu_inst, 32'h1080);
      cpu_addr = 32'h20C;
      #1;
      chk("slow_inst3", cpu_inst, 32'h1083);
      step();
      // flush during the second word of a refill for 0x40
      cpu_addr = 32'h40; mem_ack = 1'b1;
      #1;
      chk("fr_miss", {31'd0, stall_req}, 32'd1);
      step();
      step();
      flush = 1'b1;
      #1;
      chk("fr_word1_addr", mem_addr, 32'h44);
      step();
      flush = 1'b0;
      step();
      step();
      step();
      #1;
      chk("fr_remiss_stall", {31'd0, stall_req}, 32'd1);
      chk("fr_remiss_inst", cpu_inst, 32'h0);
      refill_fast(32'h40);
      #1;
      chk("fr_hit_inst", cpu_inst, 32'h1010);
      step();
      // flush in IDLE: the flush cycle still hits, the next one misses
      flush = 1'b1;
      #1;
      chk("fi_same_inst", cpu_inst, 32'h1010);
      chk("fi_same_stall", {31'd0, stall_req}, 32'd0);
      step();
      flush = 1'b0;
      #1;
      chk("fi_after_stall", {31'd0, stall_req}, 32'd1);
      chk("fi_after_inst", cpu_inst, 32'h0);
      step();
      // reset in the middle of a refill
      chk("rr_req_before", {31'd0, mem_req}, 32'd1);
      chk("rr_addr_before", mem_addr, 32'h40);
      rst = 1'b1;
      step();
      chk("rr_req", {31'd0, mem_req}, 32'd0);
      chk("rr_addr", mem_addr, 32'h0);
`ifdef INST_CACHE_STATS_EN
      chk("rr_hits", hit_cnt, 32'd0);
      chk("rr_miss", miss_cnt, 32'd0);
`endif
      rst = 1'b0; cpu_ce = 1'b0;
      #1;
      chk("rr_ce_low_stall", {31'd0, stall_req}, 32'd0);
      step();
      chk("rr_ce_low_req", {31'd0, mem_req}, 32'd0);
      cpu_ce = 1'b1; cpu_addr = 32'h40;
      #1;
      chk("rr_invalid_stall", {31'd0, stall_req}, 32'd1);
      step();
      chk("rr_restart_req", {31'd0, mem_req}, 32'd1);
      chk("rr_restart_addr", mem_addr, 32'h40);
      step();
      step();
      step();
      step();
      step();
      chk("rr_final_inst", cpu_inst, 32'h1010);
      chk("rr_final_stall", {31'd0, stall_req}, 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
